debug_rom_reader: RTL and testbench

- Bus initiator that reads a contiguous block of 64-bit words from a ROM-style slave (req/addr in, rdata out exactly one cycle later, no back-pressure) and presents them as a valid/ready stream.
- Sits in the debug module next to the debug ROM. Used for ROM self-check, for readback over DMI, and for preloading program buffers.
- Paces requests so that no response is ever dropped when the consumer stalls.

---
 rtl/dm_rom_reader_pkg.sv | 13 +
 rtl/debug_rom_reader_fifo.sv | 60 ++++++
 rtl/debug_rom_reader.sv | 166 ++++++++++++++++
 tb/tb_debug_rom_reader.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_rom_reader_pkg.sv
// Shared state encoding and constants for the debug ROM block reader.
package dm_rom_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int unsigned WordBytes       = 8;
  localparam int unsigned RomWordsDefault = 19;

endpackage

// File: rtl/debug_rom_reader_fifo.sv
// Synchronous output FIFO for the debug ROM reader; head word is held stable until popped.
module debug_rom_reader_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 64,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign count_o = count_q;
  // Empty FIFO presents zero so the output word is clean outside a transfer.
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/debug_rom_reader.sv
// Reads a block of words from the debug ROM and streams them out as valid/ready.
// Optional ROM bound check enabled by defining DEBUG_ROM_READER_BOUND_CHECK_EN.
module debug_rom_reader
  import dm_rom_reader_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned CntWidth  = 6,
  parameter int unsigned FifoDepth = 2
`ifdef DEBUG_ROM_READER_BOUND_CHECK_EN
  ,
  parameter int unsigned RomWords  = RomWordsDefault
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [CntWidth-1:0]  num_words_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 rom_req_o,
  output logic [AddrWidth-1:0] rom_addr_o,
  input  logic [DataWidth-1:0] rom_rdata_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic                 data_last_o,
  output logic                 err_o
);

  localparam int unsigned FifoCntW = $clog2(FifoDepth + 1);
  localparam int unsigned OccW     = FifoCntW + 1;
  localparam logic [AddrWidth-1:0] Stride    = AddrWidth'(DataWidth / 8);
  localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(WordBytes - 1);

  rd_state_e            state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [CntWidth-1:0]  rem_q, rem_d;
  logic [CntWidth-1:0]  num_q, num_d;
  logic [CntWidth-1:0]  pop_cnt_q, pop_cnt_d;
  logic                 inflight_q, inflight_d;
  logic                 zero_q, zero_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [DataWidth-1:0] push_data;
  logic [FifoCntW-1:0]  fifo_count;
  logic                 fifo_full, fifo_empty;
  logic                 pop, can_issue, oob, issue_req;
  logic [OccW-1:0]      occ;

`ifdef DEBUG_ROM_READER_BOUND_CHECK_EN
  localparam logic [AddrWidth-1:0] RomLimit = AddrWidth'(RomWords * WordBytes);
  assign oob = (addr_q >= RomLimit);
`else
  assign oob = 1'b0;
`endif

  // Occupancy after this cycle's pop; a word issued now lands next cycle.
  assign pop       = data_valid_o & data_ready_i;
  assign occ       = OccW'(fifo_count) + OccW'(inflight_q) - OccW'(pop);
  assign can_issue = (state_q == READ) && (rem_q != '0) && (occ < OccW'(FifoDepth));
  assign issue_req = can_issue & ~oob;

  assign rom_req_o    = issue_req;
  assign rom_addr_o   = issue_req ? addr_q : '0;
  assign push_data    = zero_q ? '0 : rom_rdata_i;
  assign data_valid_o = ~fifo_empty;
  assign data_last_o  = data_valid_o && (pop_cnt_q == num_q - CntWidth'(1));
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;

  debug_rom_reader_fifo #(
    .Depth (FifoDepth),
    .Width (DataWidth),
    .CntW  (FifoCntW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (inflight_q),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (data_o),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    num_d      = num_q;
    pop_cnt_d  = pop ? pop_cnt_q + CntWidth'(1) : pop_cnt_q;
    inflight_d = can_issue;
    zero_d     = can_issue & oob;
    done_d     = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          err_d     = 1'b0;
          pop_cnt_d = '0;
          if (num_words_i == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = base_addr_i & AlignMask;
            rem_d   = num_words_i;
            num_d   = num_words_i;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (can_issue) begin
          addr_d = addr_q + Stride;
          rem_d  = rem_q - CntWidth'(1);
          if (oob) begin
            err_d = 1'b1;
          end
          if (rem_q == CntWidth'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && data_last_o) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      num_q      <= '0;
      pop_cnt_q  <= '0;
      inflight_q <= 1'b0;
      zero_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      num_q      <= num_d;
      pop_cnt_q  <= pop_cnt_d;
      inflight_q <= inflight_d;
      zero_q     <= zero_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // The issue throttle must guarantee room for every returning word.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(inflight_q && fifo_full));

endmodule

// File: tb/tb_debug_rom_reader.sv
// Self-checking bench for debug_rom_reader with a transaction-level expected-stream model.
module tb_debug_rom_reader;

  localparam int unsigned Depth = 2;
  localparam logic [63:0] RomLimit = 64'd19 * 64'd8;
`ifdef DEBUG_ROM_READER_BOUND_CHECK_EN
  localparam bit BoundEn = 1'b1;
`else
  localparam bit BoundEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] base_addr;
  logic [5:0]  num_words;
  logic        busy, done, rom_req, data_valid, data_ready, data_last, err;
  logic [63:0] rom_addr, rom_rdata, data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_req   = 0;
  int n_pop   = 0;
  int n_done  = 0;
  int hs_cyc  = 0;
  int done_cyc = 0;

  bit live = 1'b0, check_zero = 1'b0, err_req = 1'b0, err_exp = 1'b0;
  bit m_busy = 1'b0, m_done = 1'b0, stall_prev = 1'b0;
  logic [63:0] held = '0;

  logic [63:0] exp_addr[$];
  logic [63:0] exp_word[$];
  bit          exp_last[$];
  logic [63:0] req_log[$];
  int          req_cyc[$];
  logic [63:0] pop_log[$];

  debug_rom_reader dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .num_words_i  (num_words),
    .busy_o       (busy),
    .done_o       (done),
    .rom_req_o    (rom_req),
    .rom_addr_o   (rom_addr),
    .rom_rdata_i  (rom_rdata),
    .data_o       (data),
    .data_valid_o (data_valid),
    .data_ready_i (data_ready),
    .data_last_o  (data_last),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rom_val(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_1234, ~a[31:0]};
  endfunction

  function automatic bit is_oob(input logic [63:0] a);
    return BoundEn && (a >= RomLimit);
  endfunction

  // ROM slave: one-cycle read latency, junk when not addressed.
  always @(posedge clk) rom_rdata <= rom_req ? rom_val(rom_addr) : 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Per-cycle comparison against the expected transfer streams.
  task automatic compare_cycle();
    bit accept, next_done, lastw;
    logic [63:0] a;
    if (!live) return;
    if (check_zero) begin
      chk("zero_busy", 64'(busy), 64'd0);
      chk("zero_done", 64'(done), 64'd0);
      chk("zero_req", 64'(rom_req), 64'd0);
      chk("zero_addr", rom_addr, 64'd0);
      chk("zero_data", data, 64'd0);
      chk("zero_valid", 64'(data_valid), 64'd0);
      chk("zero_last", 64'(data_last), 64'd0);
      chk("zero_err", 64'(err), 64'd0);
      check_zero = 1'b0;
    end
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    if (err_req) begin
      chk("err_flag", 64'(err), 64'(err_exp));
      err_req = 1'b0;
    end
`ifndef DEBUG_ROM_READER_BOUND_CHECK_EN
    chk("err_tied", 64'(err), 64'd0);
`endif
    if (rom_req) begin
      req_log.push_back(rom_addr);
      req_cyc.push_back(cyc);
      n_req++;
      if (exp_addr.size() == 0) fail("unexpected_req");
      else chk("req_addr", rom_addr, exp_addr.pop_front());
    end else begin
      chk("idle_addr", rom_addr, 64'd0);
    end
    if (stall_prev) begin
      chk("hold_valid", 64'(data_valid), 64'd1);
      chk("hold_data", data, held);
    end
    if (data_valid) begin
      if (exp_word.size() == 0) fail("unexpected_word");
      else begin
        chk("data", data, exp_word[0]);
        chk("last", 64'(data_last), 64'(exp_last[0]));
      end
    end
    accept    = start && !m_busy;
    next_done = 1'b0;
    if (data_valid && data_ready && exp_word.size() > 0) begin
      void'(exp_word.pop_front());
      lastw = exp_last.pop_front();
      pop_log.push_back(data);
      n_pop++;
      if (lastw) begin
        next_done = 1'b1;
        m_busy    = 1'b0;
        hs_cyc    = cyc;
      end
    end
    stall_prev = data_valid && !data_ready;
    held = data;
    if (accept) begin
      if (num_words == 6'd0) next_done = 1'b1;
      else begin
        m_busy = 1'b1;
        for (int i = 0; i < int'(num_words); i++) begin
          a = (base_addr & ~64'h7) + 64'(i) * 64'd8;
          exp_word.push_back(is_oob(a) ? 64'd0 : rom_val(a));
          exp_last.push_back(i == int'(num_words) - 1);
          if (!is_oob(a)) exp_addr.push_back(a);
        end
      end
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (!rst_n) begin
      exp_addr.delete();
      exp_word.delete();
      exp_last.delete();
      m_busy     = 1'b0;
      next_done  = 1'b0;
      stall_prev = 1'b0;
    end
    m_done = next_done;
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [63:0] b, input logic [5:0] n);
    start = 1'b1;
    base_addr = b;
    num_words = n;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input bit toggle);
    int d0 = n_done;
    int k = 0;
    while (n_done == d0 && k < limit) begin
      if (toggle) data_ready = ~data_ready;
      step();
      k++;
    end
    if (n_done == d0) fail("timeout_done");
    data_ready = 1'b1;
  endtask

  task automatic clear_logs();
    req_log.delete();
    req_cyc.delete();
    pop_log.delete();
  endtask

  initial begin
    int d0, p0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; data_ready = 1'b1;
    step();
    step();
    live = 1'b1;
    check_zero = 1'b1;
    step();
    rst_n = 1'b1;
    step();

    // Streaming read of four words.
    clear_logs();
    do_start(64'h0, 6'd4);
    wait_done(40, 1'b0);
    chk("s_nreq", 64'(req_log.size()), 64'd4);
    if (req_log.size() == 4) begin
      chk("s_addr0", req_log[0], 64'h0);
      chk("s_addr1", req_log[1], 64'h8);
      chk("s_addr2", req_log[2], 64'h10);
      chk("s_addr3", req_log[3], 64'h18);
      chk("s_consecutive", 64'(req_cyc[3] - req_cyc[0]), 64'd3);
    end
    chk("s_npop", 64'(pop_log.size()), 64'd4);
    if (pop_log.size() == 4) begin
      chk("s_word0", pop_log[0], 64'h5A5A1234_FFFFFFFF);
      chk("s_word3", pop_log[3], 64'h5A5A122C_FFFFFFE7);
    end
    chk("s_done_lat", 64'(done_cyc - hs_cyc), 64'd1);
    step();

    // Zero-length transfer.
    clear_logs();
    d0 = n_done;
    do_start(64'h40, 6'd0);
    step(); step(); step();
    chk("z_nreq", 64'(req_log.size()), 64'd0);
    chk("z_ndone", 64'(n_done - d0), 64'd1);

    // Consumer stall with six words.
    clear_logs();
    data_ready = 1'b0;
    p0 = n_pop;
    do_start(64'h200, 6'd6);
    repeat (10) step();
    chk("st_req_le_depth", 64'(req_log.size() <= Depth), 64'd1);
    chk("st_valid", 64'(data_valid), 64'd1);
    data_ready = 1'b1;
    wait_done(60, 1'b0);
    chk("st_words", 64'(n_pop - p0), 64'd6);
    if (pop_log.size() == 6) chk("st_word5", pop_log[5], 64'h5A5A101C_FFFFFDD7);
    step();

    // Misaligned base address.
    clear_logs();
    do_start(64'h2D, 6'd2);
    wait_done(40, 1'b0);
    chk("m_nreq", 64'(req_log.size()), 64'd2);
    if (req_log.size() == 2) begin
      chk("m_addr0", req_log[0], 64'h28);
      chk("m_addr1", req_log[1], 64'h30);
    end

    // Alternating ready.
    p0 = n_pop;
    do_start(64'h400, 6'd5);
    wait_done(80, 1'b1);
    chk("t_words", 64'(n_pop - p0), 64'd5);
    step();

    // Reset while a request is in flight.
    do_start(64'h100, 6'd5);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_zero = 1'b1;
    step();
    step();
    clear_logs();
    p0 = n_pop;
    do_start(64'h40, 6'd1);
    wait_done(40, 1'b0);
    chk("r_words", 64'(n_pop - p0), 64'd1);
    if (pop_log.size() == 1) chk("r_word0", pop_log[0], 64'h5A5A1274_FFFFFFBF);
    step();

`ifdef DEBUG_ROM_READER_BOUND_CHECK_EN
    // Read running past the end of the ROM.
    clear_logs();
    do_start(64'h88, 6'd3);
    wait_done(40, 1'b0);
    chk("b_nreq", 64'(req_log.size()), 64'd2);
    if (req_log.size() == 2) begin
      chk("b_addr0", req_log[0], 64'h88);
      chk("b_addr1", req_log[1], 64'h90);
    end
    if (pop_log.size() == 3) chk("b_word2", pop_log[2], 64'h0);
    err_req = 1'b1; err_exp = 1'b1;
    step();
    err_req = 1'b1; err_exp = 1'b1;
    step();
    do_start(64'h0, 6'd1);
    err_req = 1'b1; err_exp = 1'b0;
    wait_done(40, 1'b0);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
